// File: rtl/pipeline_cpu_core_p.sv
// Three-stage (FD/EM/WB) core for the 10-bit ISA with parametrised data/address widths and external memories.
// Fetch-to-EM is 1 cycle and fetch-to-register-write is 2 cycles; FWD_EM=0 stalls FD one cycle on each EM dependency.
module pipeline_cpu_core_p #(
    parameter int DATA_W   = 10,
    parameter int ADDR_W   = 10,
    parameter int FWD_EM   = 1,
    parameter int RET_W    = 16,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [9:0]        imem_data,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_we,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              halted,
    output logic [RET_W-1:0]  instret
);

    localparam logic [2:0] OP_R    = 3'b000;
    localparam logic [2:0] OP_SH   = 3'b001;
    localparam logic [2:0] OP_BNE  = 3'b010;
    localparam logic [2:0] OP_ADDI = 3'b011;
    localparam logic [2:0] OP_JMP  = 3'b100;
    localparam logic [2:0] OP_BEQ  = 3'b101;
    localparam logic [2:0] OP_LD   = 3'b110;
    localparam logic [2:0] OP_ST   = 3'b111;

    function automatic logic writes_reg(input logic [2:0] op, input logic [1:0] imm);
        return (op == OP_R) || (op == OP_SH && !imm[1]) || (op == OP_ADDI) || (op == OP_LD);
    endfunction

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              stop_q;
    logic [DATA_W-1:0] regs [8];

    logic              em_vld_q;
    logic [2:0]        em_op_q;
    logic [1:0]        em_imm_q;
    logic [2:0]        em_dst_q;
    logic [DATA_W-1:0] em_a_q, em_b_q;

    logic              wb_vld_q, wb_wr_q, wb_halt_q;
    logic [2:0]        wb_dst_q;
    logic [DATA_W-1:0] wb_dat_q;

    logic [2:0]        fd_op, fd_rs, fd_rt;
    logic [1:0]        fd_imm;
    logic              fd_rd_a, fd_rd_b, fd_halt;
    logic [DATA_W-1:0] opa, opb, alu, em_res;
    logic              em_wr, stall, issue;

    assign fd_op   = imem_data[9:7];
    assign fd_rs   = {imem_data[2], imem_data[6:5]};
    assign fd_rt   = {imem_data[2], imem_data[4:3]};
    assign fd_imm  = imem_data[1:0];
    assign fd_halt = (fd_op == OP_SH) && (fd_imm == 2'b10);

    always_comb begin
        fd_rd_a = 1'b0;
        fd_rd_b = 1'b0;
        case (fd_op)
            OP_R, OP_BNE, OP_BEQ, OP_ST: begin
                fd_rd_a = 1'b1;
                fd_rd_b = 1'b1;
            end
            OP_ADDI, OP_LD: fd_rd_a = 1'b1;
            OP_SH:          fd_rd_a = !fd_imm[1];
            default: ;
        endcase
    end

    assign em_wr = em_vld_q && writes_reg(em_op_q, em_imm_q);

    // EM bypass beats WB write-through, which beats the stored register value
    always_comb begin
        opa = regs[fd_rs];
        opb = regs[fd_rt];
        if (wb_wr_q && wb_dst_q == fd_rs) opa = wb_dat_q;
        if (wb_wr_q && wb_dst_q == fd_rt) opb = wb_dat_q;
        if (FWD_EM != 0 && em_wr && em_dst_q == fd_rs) opa = em_res;
        if (FWD_EM != 0 && em_wr && em_dst_q == fd_rt) opb = em_res;
    end

    assign stall = (FWD_EM == 0) && !stop_q && em_wr &&
                   ((fd_rd_a && fd_rs == em_dst_q) || (fd_rd_b && fd_rt == em_dst_q));
    assign issue = !stop_q && !stall;

    always_comb begin
        pc_d = pc_q;
        if (issue && !fd_halt) begin
            pc_d = pc_q + ADDR_W'(1);
            if (fd_op == OP_JMP)
                pc_d = ADDR_W'($signed(imem_data[6:0]));
            else if ((fd_op == OP_BNE && opa != opb) || (fd_op == OP_BEQ && opa == opb))
                pc_d = pc_q + ADDR_W'(fd_imm);
        end
    end

    always_comb begin
        alu = '0;
        case (em_op_q)
            OP_R: begin
                case (em_imm_q)
                    2'b00: alu = em_a_q + em_b_q;
                    2'b01: alu = em_a_q - em_b_q;
                    2'b10: alu = ($signed(em_a_q) < $signed(em_b_q)) ? DATA_W'(1) : '0;
                    default: alu = ~(em_a_q & em_b_q);
                endcase
            end
            OP_SH: begin
                if (em_imm_q == 2'b00)      alu = em_a_q >> 1;
                else if (em_imm_q == 2'b01) alu = em_a_q << 1;
            end
            OP_ADDI:      alu = em_a_q + DATA_W'($signed(em_imm_q));
            OP_LD, OP_ST: alu = em_a_q + DATA_W'(em_imm_q);
            default: ;
        endcase
    end

    assign em_res     = (em_op_q == OP_LD) ? dmem_rdata : alu;
    assign imem_addr  = pc_q;
    assign dmem_addr  = alu[ADDR_W-1:0];
    assign dmem_we    = em_vld_q && (em_op_q == OP_ST);
    assign dmem_wdata = dmem_we ? em_b_q : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= ADDR_W'(RESET_PC);
            stop_q    <= 1'b0;
            em_vld_q  <= 1'b0;
            em_op_q   <= '0;
            em_imm_q  <= '0;
            em_dst_q  <= '0;
            em_a_q    <= '0;
            em_b_q    <= '0;
            wb_vld_q  <= 1'b0;
            wb_wr_q   <= 1'b0;
            wb_halt_q <= 1'b0;
            wb_dst_q  <= '0;
            wb_dat_q  <= '0;
            instret   <= '0;
            halted    <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            // once HALT issues, FD only ever produces bubbles
            stop_q    <= stop_q | (issue && fd_halt);
            em_vld_q  <= issue;
            em_op_q   <= fd_op;
            em_imm_q  <= fd_imm;
            em_dst_q  <= fd_rt;
            em_a_q    <= opa;
            em_b_q    <= opb;
            wb_vld_q  <= em_vld_q;
            wb_wr_q   <= em_wr;
            wb_dst_q  <= em_dst_q;
            wb_dat_q  <= em_res;
            wb_halt_q <= em_vld_q && (em_op_q == OP_SH) && (em_imm_q == 2'b10);
            if (wb_vld_q)  instret <= instret + RET_W'(1);
            if (wb_halt_q) halted  <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (wb_wr_q) begin
            regs[wb_dst_q] <= wb_dat_q;
        end
    end

endmodule
